// File: rtl/unidade_controle_param.sv
// unidade_controle_param: sequencing FSM for the pair/sequence memory game.
// Owns the inactivity timer, the LED on/off phase timer, the blink counter
// and the round/hit counters; the datapath only reports acertou/repetida.
// Optional feature macro: ERROS_EN (count wrong plays, defeat at MAX_ERROS).
//
// state            | code | meaning
// ST_INICIAL       | 0    | idle after reset, waiting for jogar
// ST_PREPARACAO    | 1    | new game, counters cleared, waiting for confirma
// ST_INICIA_SEQ    | 2    | load level pattern, clear hit registers
// ST_ESPERA        | 3    | waiting for a play
// ST_REGISTRA      | 4    | load play register
// ST_COMPARACAO    | 5    | datapath compare result is valid
// ST_NOVO_ACERTO   | 6    | store a new distinct hit
// ST_ERRO          | 7    | wrong play
// ST_PISCA_ON      | 8    | LED on-phase
// ST_FIM_RODADA    | 9    | round closed, decide next round or win
// ST_FINAL_ACERTO  | A    | game won (terminal)
// ST_PROXIMA       | B    | advance round index
// ST_PISCA_OFF     | C    | LED off-phase
// ST_DERROTA       | D    | too many wrong plays (terminal)
// ST_TIMEOUT       | E    | inactivity timeout (terminal)
module unidade_controle_param #(
  parameter int NUM_RODADAS    = 16,
  parameter int ACERTOS_RODADA = 2,
  parameter int PISCADAS       = 3,
  parameter int T_ON           = 500,
  parameter int T_OFF          = 500,
  parameter int T_TIMEOUT      = 5000,
  parameter int MAX_ERROS      = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  jogar,
  input  logic                                  confirma,
  input  logic                                  tem_jogada,
  input  logic                                  acertou,
  input  logic                                  repetida,
  output logic                                  registraR,
  output logic                                  registraA,
  output logic                                  zeraA,
  output logic                                  registraL,
  output logic                                  leds,
  output logic [$clog2(NUM_RODADAS)-1:0]        rodada,
  output logic [$clog2(ACERTOS_RODADA+1)-1:0]   acertos,
  output logic [2:0]                            displayAddr,
  output logic                                  pronto,
  output logic                                  ganhou,
  output logic                                  timeout_out,
  output logic [3:0]                            db_estado
);

  localparam int RW    = $clog2(NUM_RODADAS);
  localparam int AW    = $clog2(ACERTOS_RODADA + 1);
  localparam int TW    = $clog2(T_TIMEOUT);
  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int PW    = $clog2(T_MAX + 1);
  localparam int BW    = $clog2(PISCADAS + 1);

  localparam logic [3:0] ST_INICIAL      = 4'h0;
  localparam logic [3:0] ST_PREPARACAO   = 4'h1;
  localparam logic [3:0] ST_INICIA_SEQ   = 4'h2;
  localparam logic [3:0] ST_ESPERA       = 4'h3;
  localparam logic [3:0] ST_REGISTRA     = 4'h4;
  localparam logic [3:0] ST_COMPARACAO   = 4'h5;
  localparam logic [3:0] ST_NOVO_ACERTO  = 4'h6;
  localparam logic [3:0] ST_ERRO         = 4'h7;
  localparam logic [3:0] ST_PISCA_ON     = 4'h8;
  localparam logic [3:0] ST_FIM_RODADA   = 4'h9;
  localparam logic [3:0] ST_FINAL_ACERTO = 4'hA;
  localparam logic [3:0] ST_PROXIMA      = 4'hB;
  localparam logic [3:0] ST_PISCA_OFF    = 4'hC;
  localparam logic [3:0] ST_DERROTA      = 4'hD;
  localparam logic [3:0] ST_TIMEOUT      = 4'hE;

  localparam logic [TW-1:0] TMO_LOAD       = TW'(T_TIMEOUT - 1);
  localparam logic [PW-1:0] ON_LOAD        = PW'(T_ON - 1);
  localparam logic [PW-1:0] OFF_LOAD       = PW'(T_OFF - 1);
  localparam logic [RW-1:0] ULTIMA_RODADA  = RW'(NUM_RODADAS - 1);
  localparam logic [AW-1:0] ULTIMO_ACERTO  = AW'(ACERTOS_RODADA - 1);
  localparam logic [BW-1:0] ULTIMA_PISCADA = BW'(PISCADAS - 1);

  if (NUM_RODADAS < 2 || ACERTOS_RODADA < 1 || PISCADAS < 1 || T_ON < 1 ||
      T_OFF < 1 || T_TIMEOUT < 2 || MAX_ERROS < 1) begin : g_param_invalido
    $error("unidade_controle_param: parameter out of range");
  end

  logic [3:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] fase_q, fase_d;
  logic [BW-1:0] pisc_q, pisc_d;
  logic [RW-1:0] rodada_q, rodada_d;
  logic [AW-1:0] acertos_q, acertos_d;
  logic          contando;
  logic          expirou;

`ifdef ERROS_EN
  localparam int EW = $clog2(MAX_ERROS + 1);
  localparam logic [EW-1:0] ULTIMO_ERRO = EW'(MAX_ERROS - 1);
  logic [EW-1:0] erros_q, erros_d;
`endif

  // Inactivity timer runs only while the player is expected to act
  always_comb begin
    contando = (state_q == ST_PREPARACAO) || (state_q == ST_INICIA_SEQ) ||
               (state_q == ST_ESPERA)     || (state_q == ST_REGISTRA)   ||
               (state_q == ST_COMPARACAO) || (state_q == ST_ERRO);
    expirou  = contando && (tmo_q == '0);
  end

  // Next-state, timers and counters; timer expiry overrides every other transition
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    fase_d    = fase_q;
    pisc_d    = pisc_q;
    rodada_d  = rodada_q;
    acertos_d = acertos_q;
`ifdef ERROS_EN
    erros_d   = erros_q;
`endif

    if (contando) tmo_d = tmo_q - TW'(1);
    if (tem_jogada) tmo_d = TMO_LOAD;

    case (state_q)
      // Idle and terminal states keep the timer armed so preparacao starts fresh;
      // counters are cleared on the way in so preparacao already shows zeros.
      ST_INICIAL, ST_FINAL_ACERTO, ST_TIMEOUT, ST_DERROTA: begin
        tmo_d = TMO_LOAD;
        if (jogar) begin
          state_d   = ST_PREPARACAO;
          rodada_d  = '0;
          acertos_d = '0;
`ifdef ERROS_EN
          erros_d   = '0;
`endif
        end
      end
      ST_PREPARACAO: begin
        rodada_d  = '0;
        acertos_d = '0;
`ifdef ERROS_EN
        erros_d   = '0;
`endif
        if (confirma) state_d = ST_INICIA_SEQ;
      end
      ST_INICIA_SEQ: begin
        acertos_d = '0;
        state_d   = ST_ESPERA;
      end
      ST_ESPERA: begin
        if (tem_jogada) state_d = ST_REGISTRA;
      end
      ST_REGISTRA: begin
        state_d = ST_COMPARACAO;
      end
      ST_COMPARACAO: begin
        if (!acertou)      state_d = ST_ERRO;
        else if (repetida) state_d = ST_ESPERA;
        else               state_d = ST_NOVO_ACERTO;
      end
      ST_NOVO_ACERTO: begin
        acertos_d = acertos_q + AW'(1);
        if (acertos_q == ULTIMO_ACERTO) begin
          state_d = ST_PISCA_ON;
          fase_d  = ON_LOAD;
          pisc_d  = '0;
        end else begin
          state_d = ST_ESPERA;
        end
      end
      ST_ERRO: begin
`ifdef ERROS_EN
        erros_d = erros_q + EW'(1);
        if (erros_q == ULTIMO_ERRO) state_d = ST_DERROTA;
        else                        state_d = ST_ESPERA;
`else
        state_d = ST_ESPERA;
`endif
      end
      ST_PISCA_ON: begin
        if (fase_q == '0) begin
          if (pisc_q == ULTIMA_PISCADA) begin
            state_d = ST_FIM_RODADA;
          end else begin
            pisc_d  = pisc_q + BW'(1);
            fase_d  = OFF_LOAD;
            state_d = ST_PISCA_OFF;
          end
        end else begin
          fase_d = fase_q - PW'(1);
        end
      end
      ST_PISCA_OFF: begin
        if (fase_q == '0) begin
          fase_d  = ON_LOAD;
          state_d = ST_PISCA_ON;
        end else begin
          fase_d = fase_q - PW'(1);
        end
      end
      ST_FIM_RODADA: begin
        if (rodada_q == ULTIMA_RODADA) state_d = ST_FINAL_ACERTO;
        else                           state_d = ST_PROXIMA;
      end
      ST_PROXIMA: begin
        rodada_d  = rodada_q + RW'(1);
        acertos_d = '0;
        state_d   = ST_INICIA_SEQ;
      end
      default: begin
        state_d = ST_INICIAL;
      end
    endcase

    if (expirou) state_d = ST_TIMEOUT;
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_INICIAL;
      tmo_q     <= '0;
      fase_q    <= '0;
      pisc_q    <= '0;
      rodada_q  <= '0;
      acertos_q <= '0;
`ifdef ERROS_EN
      erros_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      fase_q    <= fase_d;
      pisc_q    <= pisc_d;
      rodada_q  <= rodada_d;
      acertos_q <= acertos_d;
`ifdef ERROS_EN
      erros_q   <= erros_d;
`endif
    end
  end

  // Moore output decode
  always_comb begin
    registraR   = (state_q == ST_REGISTRA);
    registraA   = (state_q == ST_NOVO_ACERTO);
    zeraA       = (state_q == ST_PREPARACAO) || (state_q == ST_INICIA_SEQ);
    registraL   = (state_q == ST_INICIA_SEQ);
    leds        = (state_q == ST_PISCA_ON);
    ganhou      = (state_q == ST_FINAL_ACERTO);
    timeout_out = (state_q == ST_TIMEOUT);
    pronto      = (state_q == ST_FINAL_ACERTO) || (state_q == ST_TIMEOUT) ||
                  (state_q == ST_DERROTA);
    case (state_q)
      ST_PREPARACAO:   displayAddr = 3'b000;
      ST_ESPERA:       displayAddr = 3'b001;
      ST_FINAL_ACERTO: displayAddr = 3'b010;
      ST_TIMEOUT:      displayAddr = 3'b011;
      ST_DERROTA:      displayAddr = 3'b100;
      default:         displayAddr = 3'b111;
    endcase
    rodada    = rodada_q;
    acertos   = acertos_q;
    db_estado = state_q;
  end

endmodule

// File: tb/tb_unidade_controle_param.sv
// Randomised game-level bench for unidade_controle_param. Each game is planned
// as a list of player actions; a game-rule model turns the plan into the
// expected sequence of states (with round, hit count and dwell time), which a
// separate monitor consumes whenever the DUT changes state.
module tb_unidade_controle_param;
  localparam int NR = 2, AR = 2, PS = 2, TON = 3, TOFF = 2, TTO = 20, ME = 2;
  localparam int K_OK = 0, K_ERR = 1, K_REP = 2, K_TMO = 3, K_RST = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic jogar = 1'b0, confirma = 1'b0, tem_jogada = 1'b0, acertou = 1'b0, repetida = 1'b0;
  logic registraR, registraA, zeraA, registraL, leds, pronto, ganhou, timeout_out;
  logic [$clog2(NR)-1:0]   rodada;
  logic [$clog2(AR+1)-1:0] acertos;
  logic [2:0] displayAddr;
  logic [3:0] db_estado;

  unidade_controle_param #(
    .NUM_RODADAS(NR), .ACERTOS_RODADA(AR), .PISCADAS(PS), .T_ON(TON),
    .T_OFF(TOFF), .T_TIMEOUT(TTO), .MAX_ERROS(ME)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .confirma(confirma),
    .tem_jogada(tem_jogada), .acertou(acertou), .repetida(repetida),
    .registraR(registraR), .registraA(registraA), .zeraA(zeraA),
    .registraL(registraL), .leds(leds), .rodada(rodada), .acertos(acertos),
    .displayAddr(displayAddr), .pronto(pronto), .ganhou(ganhou),
    .timeout_out(timeout_out), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct { logic [3:0] st; int rod; int ac; int dur; } exp_t;
  typedef struct { int kind; int w; } act_t;
  exp_t exp_q[$];
  act_t act_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [3:0] st, input int rod, input int ac, input int dur);
    exp_t e;
    e.st = st; e.rod = rod; e.ac = ac; e.dur = dur;
    exp_q.push_back(e);
  endtask

  function automatic logic [2:0] disp_of(input logic [3:0] s);
    case (s)
      4'h1:    return 3'b000;
      4'h3:    return 3'b001;
      4'hA:    return 3'b010;
      4'hE:    return 3'b011;
      4'hD:    return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  function automatic int pick(input int flavor, input int ac, input int plays);
    int r;
    r = $urandom_range(0, 99);
    if (flavor == 1 && plays >= 2 && (r < 40 || plays >= 6)) return K_TMO;
    if (flavor == 2 && plays >= 2 && (r < 40 || plays >= 6)) return K_RST;
    if (plays >= 40) return K_OK;
    r = $urandom_range(0, 99);
    if (flavor == 3 && r < 50) return K_ERR;
    if (r < 10) return K_ERR;
    if (ac > 0 && r < 30) return K_REP;
    return K_OK;
  endfunction

  // Game-rule model: idle counts cycles the player has been expected to act
  // since the inactivity timer was last cleared.
  task automatic plan_game(input int flavor, output logic [3:0] term, output int pw);
    int rod, ac, err, idle, plays;
    bit done;
    act_t a;
    rod = 0; ac = 0; err = 0; plays = 0; done = 0; term = 4'h0;
    pw = $urandom_range(0, 3);
    push(4'h1, 0, 0, pw + 1);
    idle = pw + 1;
    push(4'h2, 0, 0, 1);
    idle++;
    while (!done) begin
      a.w = $urandom_range(0, 3);
      a.kind = pick(flavor, ac, plays);
      act_q.push_back(a);
      if (a.kind == K_TMO) begin
        push(4'h3, rod, ac, TTO - idle);
        push(4'hE, rod, ac, 0);
        term = 4'hE; done = 1;
      end else if (a.kind == K_RST) begin
        push(4'h3, rod, ac, a.w + 1);
        push(4'h0, 0, 0, 0);
        term = 4'h0; done = 1;
      end else begin
        push(4'h3, rod, ac, a.w + 1);
        plays++;
        push(4'h4, rod, ac, 1);
        push(4'h5, rod, ac, 1);
        idle = 2;
        if (a.kind == K_ERR) begin
          push(4'h7, rod, ac, 1);
          idle = 3;
          err++;
`ifdef ERROS_EN
          if (err == ME) begin
            push(4'hD, rod, ac, 0);
            term = 4'hD; done = 1;
          end
`endif
        end else if (a.kind == K_OK) begin
          push(4'h6, rod, ac, 1);
          ac++;
          if (ac == AR) begin
            for (int k = 0; k < PS; k++) begin
              push(4'h8, rod, ac, TON);
              if (k < PS - 1) push(4'hC, rod, ac, TOFF);
            end
            push(4'h9, rod, ac, 1);
            if (rod == NR - 1) begin
              push(4'hA, rod, ac, 0);
              term = 4'hA; done = 1;
            end else begin
              push(4'hB, rod, ac, 1);
              rod++;
              ac = 0;
              push(4'h2, rod, 0, 1);
              idle++;
            end
          end
        end
      end
    end
  endtask

  task automatic wait_state(input logic [3:0] s);
    int n;
    n = 0;
    while (db_estado !== s) begin
      @(negedge clock);
      n++;
      if (n > 500) begin
        $display("FAIL wait_state estado=%0h expected=%0h", db_estado, s);
        $fatal(1, "state wait expired");
      end
    end
  endtask

  task automatic run_game(input logic [3:0] term, input int pw);
    act_t a;
    acertou = 1'($urandom); tem_jogada = 1'b1; @(negedge clock); tem_jogada = 1'b0;
    confirma = 1'b1; @(negedge clock); confirma = 1'b0;
    jogar = 1'b1; @(negedge clock); jogar = 1'b0;
    wait_state(4'h1);
    repeat (pw) @(negedge clock);
    confirma = 1'b1; @(negedge clock); confirma = 1'b0;
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      wait_state(4'h3);
      if (a.kind != K_TMO) begin
        if (a.w >= 1) begin
          jogar = 1'b1; @(negedge clock); jogar = 1'b0;
          repeat (a.w - 1) @(negedge clock);
        end
        if (a.kind == K_RST) begin
          reset = 1'b1; @(negedge clock); reset = 1'b0;
        end else begin
          acertou  = (a.kind != K_ERR);
          repetida = (a.kind == K_REP) ? 1'b1 : 1'($urandom);
          if (a.kind == K_OK) repetida = 1'b0;
          tem_jogada = 1'b1; @(negedge clock); tem_jogada = 1'b0;
        end
      end
    end
    wait_state(term);
  endtask

  // Monitor: pops the next expected state on every DUT state change
  initial begin : monitor
    exp_t cur;
    int cyc;
    logic [3:0] last;
    bit have;
    have = 0; last = 4'hF; cyc = 0;
    forever begin
      @(negedge clock);
      if (db_estado !== last) begin
        if (have && cur.dur != 0) chk("duracao", cyc, cur.dur);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fila_vazia estado=%0h expected=none", db_estado);
          have = 0;
        end else begin
          cur = exp_q.pop_front();
          have = 1;
        end
        cyc = 0;
        last = db_estado;
      end
      cyc++;
      if (have) begin
        chk("db_estado", db_estado, cur.st);
        chk("rodada", rodada, cur.rod);
        chk("acertos", acertos, cur.ac);
        chk("leds", leds, cur.st == 4'h8);
        chk("registraR", registraR, cur.st == 4'h4);
        chk("registraA", registraA, cur.st == 4'h6);
        chk("zeraA", zeraA, cur.st == 4'h1 || cur.st == 4'h2);
        chk("registraL", registraL, cur.st == 4'h2);
        chk("pronto", pronto, cur.st == 4'hA || cur.st == 4'hE || cur.st == 4'hD);
        chk("ganhou", ganhou, cur.st == 4'hA);
        chk("timeout_out", timeout_out, cur.st == 4'hE);
        chk("displayAddr", displayAddr, disp_of(cur.st));
      end
    end
  end

  initial begin : stim
    logic [3:0] term;
    int pw;
    push(4'h0, 0, 0, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int g = 0; g < 24; g++) begin
      plan_game(g % 4, term, pw);
      run_game(term, pw);
    end
    repeat (5) @(negedge clock);
    chk("fila_final", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
